// File: rtl/mul_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : mul_arbiter
// Purpose  : Round-robin arbiter that shares one sequential 8x8 shift-add
//            multiplier among NREQ requesters. The winner's operands are
//            latched, the multiplier is started for one cycle, and the 17-bit
//            product is returned with a one-cycle per-requester done pulse.
// Options  : MUL_ARB_TIMEOUT_EN - bound the WAIT state to TIMEOUT cycles;
//            on expiry return result 0 and pulse err together with done.
// Revision : 1.0 - initial release
//==============================================================================
module mul_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                ck_i,
   input  logic                rst_i,
   input  logic [NREQ-1:0]     req_i,
   input  logic [NREQ*8-1:0]   a_in_i,
   input  logic [NREQ*8-1:0]   b_in_i,
   output logic [NREQ-1:0]     gnt_o,
   output logic [NREQ-1:0]     done_o,
   output logic [16:0]         result_o,
   output logic                busy_o,
   output logic                err_o,
   output logic [7:0]          mul_a_o,
   output logic [7:0]          mul_b_o,
   output logic                mul_start_o,
   input  logic [16:0]         mul_o_i,
   input  logic                mul_fin_i
);

   localparam int            C_OW      = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [C_OW-1:0] C_LAST  = C_OW'(NREQ - 1);

   // Parameter sanity: the requester field is 8 bits wide per slot and the
   // timeout must allow at least one WAIT cycle.
   if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
      $error("mul_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t            state_q,  state_d;
   logic [C_OW-1:0]   owner_q,  owner_d;
   logic [C_OW-1:0]   ptr_q,    ptr_d;
   logic [7:0]        mul_a_q,  mul_a_d;
   logic [7:0]        mul_b_q,  mul_b_d;
   logic [16:0]       result_q, result_d;

`ifdef MUL_ARB_TIMEOUT_EN
   localparam int              C_TW       = $clog2(TIMEOUT + 1);
   localparam logic [C_TW-1:0] C_TMO_LAST = C_TW'(TIMEOUT - 1);

   logic [C_TW-1:0]   cnt_q, cnt_d;
   logic              to_q,  to_d;
`endif

   logic              w_found;
   logic [C_OW-1:0]   w_pick;
   logic [C_OW-1:0]   w_idx;
   logic [7:0]        w_sel_a;
   logic [7:0]        w_sel_b;
   logic [NREQ-1:0]   w_owner_oh;

   // Round-robin search: first active request above the last winner, wrapping.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = ptr_q;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = (w_idx == C_LAST) ? '0 : w_idx + C_OW'(1);
         if (!w_found && req_i[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
   end

   // Operand selection for the candidate winner.
   always_comb begin
      w_sel_a = '0;
      w_sel_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_pick == C_OW'(i)) begin
            w_sel_a = a_in_i[i*8 +: 8];
            w_sel_b = b_in_i[i*8 +: 8];
         end
      end
   end

   // One-hot decode of the current owner, used for gnt and done.
   always_comb begin
      w_owner_oh = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_owner_oh[i] = (owner_q == C_OW'(i));
      end
   end

   // State and datapath registers; ptr resets to the last slot so slot 0 wins first.
   always_ff @(posedge ck_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         owner_q  <= '0;
         ptr_q    <= C_LAST;
         mul_a_q  <= '0;
         mul_b_q  <= '0;
         result_q <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
         cnt_q    <= '0;
         to_q     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         ptr_q    <= ptr_d;
         mul_a_q  <= mul_a_d;
         mul_b_q  <= mul_b_d;
         result_q <= result_d;
`ifdef MUL_ARB_TIMEOUT_EN
         cnt_q    <= cnt_d;
         to_q     <= to_d;
`endif
      end
   end

   // Next-state logic and state-decoded outputs.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      ptr_d       = ptr_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      result_d    = result_q;
      gnt_o       = '0;
      done_o      = '0;
      mul_start_o = 1'b0;
      err_o       = 1'b0;
      busy_o      = (state_q != ST_IDLE);
`ifdef MUL_ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
      to_d        = to_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (w_found) begin
               owner_d = w_pick;
               ptr_d   = w_pick;
               mul_a_d = w_sel_a;
               mul_b_d = w_sel_b;
               state_d = ST_START;
`ifdef MUL_ARB_TIMEOUT_EN
               to_d    = 1'b0;
`endif
            end
         end

         // fin may still be high from the previous operation; it is not sampled here.
         ST_START: begin
            gnt_o       = w_owner_oh;
            mul_start_o = 1'b1;
            state_d     = ST_WAIT;
`ifdef MUL_ARB_TIMEOUT_EN
            cnt_d       = '0;
`endif
         end

         ST_WAIT: begin
            if (mul_fin_i) begin
               result_d = mul_o_i;
               state_d  = ST_DONE;
            end
`ifdef MUL_ARB_TIMEOUT_EN
            else if (cnt_q == C_TMO_LAST) begin
               result_d = '0;
               to_d     = 1'b1;
               state_d  = ST_DONE;
            end else begin
               cnt_d = cnt_q + C_TW'(1);
            end
`endif
         end

         ST_DONE: begin
            done_o  = w_owner_oh;
`ifdef MUL_ARB_TIMEOUT_EN
            err_o   = to_q;
`endif
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign mul_a_o  = mul_a_q;
   assign mul_b_o  = mul_b_q;
   assign result_o = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_mul_arbiter
// Purpose  : Directed scoreboard bench for mul_arbiter with a shift-add
//            multiplier stand-in. Stimulus pushes expected grants and
//            completions; monitors pop and compare whenever the DUT drives
//            gnt/mul_start or done/err. MUL_ARB_TIMEOUT_EN adds the timeout case.
// Revision : 1.0 - initial release
//==============================================================================
module tb_mul_arbiter;

   localparam int NREQ = 4;

   logic              ck = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [NREQ*8-1:0] a_in;
   logic [NREQ*8-1:0] b_in;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   done;
   logic [16:0]       result;
   logic              busy;
   logic              err;
   logic [7:0]        mul_a;
   logic [7:0]        mul_b;
   logic              mul_start;
   logic [16:0]       mul_o;
   logic              mul_fin;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 ck = ~ck;
   always @(posedge ck) cyc <= cyc + 1;

   mul_arbiter #(.NREQ(NREQ), .TIMEOUT(16)) u_dut (
      .ck_i        (ck),
      .rst_i       (rst),
      .req_i       (req),
      .a_in_i      (a_in),
      .b_in_i      (b_in),
      .gnt_o       (gnt),
      .done_o      (done),
      .result_o    (result),
      .busy_o      (busy),
      .err_o       (err),
      .mul_a_o     (mul_a),
      .mul_b_o     (mul_b),
      .mul_start_o (mul_start),
      .mul_o_i     (mul_o),
      .mul_fin_i   (mul_fin)
   );

   // Multiplier stand-in: load on start, 8 shift-add steps, fin stays high until next start.
   logic [16:0] m_acc   = '0;
   logic [16:0] m_mc    = '0;
   logic [7:0]  m_mp    = '0;
   int          m_cnt   = 0;
   logic        m_fin   = 1'b0;
   logic        force_fin = 1'b0;
   logic        stuck_fin = 1'b0;

   always @(posedge ck) begin
      if (mul_start) begin
         m_acc <= '0;
         m_mc  <= {9'd0, mul_a};
         m_mp  <= mul_b;
         m_cnt <= 8;
         m_fin <= 1'b0;
      end else if (m_cnt != 0) begin
         m_acc <= m_acc + (m_mp[0] ? m_mc : 17'd0);
         m_mc  <= m_mc << 1;
         m_mp  <= m_mp >> 1;
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) m_fin <= 1'b1;
      end
   end

   assign mul_o   = m_acc;
   assign mul_fin = (m_fin | force_fin) & ~stuck_fin;

   typedef struct {
      int          who;
      logic [16:0] res;
      logic        err;
      int          at;
   } done_exp_t;

   typedef struct {
      int          who;
      logic [7:0]  a;
      logic [7:0]  b;
      int          at;
   } gnt_exp_t;

   done_exp_t done_q[$];
   gnt_exp_t  gnt_q[$];
   done_exp_t ed;
   gnt_exp_t  eg;

   function automatic logic [NREQ-1:0] onehot(input int i);
      logic [NREQ-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Completion monitor.
   always @(negedge ck) begin
      if (done != '0 || err) begin
         checks++;
         if (done_q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected cyc=%0d done=%b err=%b result=%h required=no completion",
                     cyc, done, err, result);
         end else begin
            ed = done_q.pop_front();
            if (done !== onehot(ed.who) || result !== ed.res || err !== ed.err || cyc != ed.at) begin
               errors++;
               $display("FAIL done_check cyc=%0d done=%b result=%h err=%b required cyc=%0d done=%b result=%h err=%b",
                        cyc, done, result, err, ed.at, onehot(ed.who), ed.res, ed.err);
            end
         end
      end
   end

   // Grant / start monitor.
   always @(negedge ck) begin
      if (gnt != '0 || mul_start) begin
         checks++;
         if (gnt_q.size() == 0) begin
            errors++;
            $display("FAIL gnt_unexpected cyc=%0d gnt=%b mul_start=%b required=no grant",
                     cyc, gnt, mul_start);
         end else begin
            eg = gnt_q.pop_front();
            if (gnt !== onehot(eg.who) || mul_start !== 1'b1 || mul_a !== eg.a ||
                mul_b !== eg.b || cyc != eg.at) begin
               errors++;
               $display("FAIL gnt_check cyc=%0d gnt=%b start=%b a=%0d b=%0d required cyc=%0d gnt=%b start=1 a=%0d b=%0d",
                        cyc, gnt, mul_start, mul_a, mul_b, eg.at, onehot(eg.who), eg.a, eg.b);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h required=%0h", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge ck);
      #1;
   endtask

   task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
      a_in[i*8 +: 8] = a;
      b_in[i*8 +: 8] = b;
   endtask

   task automatic expect_op(input int who, input logic [7:0] a, input logic [7:0] b,
                            input logic [16:0] res, input logic e, input int gat,
                            input int dat, input bit with_done);
      gnt_exp_t  g;
      done_exp_t d;
      g.who = who; g.a = a; g.b = b; g.at = gat;
      gnt_q.push_back(g);
      if (with_done) begin
         d.who = who; d.res = res; d.err = e; d.at = dat;
         done_q.push_back(d);
      end
   endtask

   initial begin
      int k;
      rst  = 1'b1;
      req  = '0;
      a_in = '0;
      b_in = '0;
      tick(3);

      // Reset state
      chk("rst_gnt",       32'(gnt),       32'd0);
      chk("rst_done",      32'(done),      32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_err",       32'(err),       32'd0);
      chk("rst_mul_start", 32'(mul_start), 32'd0);
      chk("rst_result",    32'(result),    32'd0);
      chk("rst_mul_a",     32'(mul_a),     32'd0);
      chk("rst_mul_b",     32'(mul_b),     32'd0);
      rst = 1'b0;
      tick(1);

      // Single request: 200*255 = 51000
      k = cyc;
      set_op(0, 8'd200, 8'd255);
      req = 4'b0001;
      expect_op(0, 8'd200, 8'd255, 17'h0C738, 1'b0, k + 1, k + 11, 1'b1);
      tick(1);
      chk("t1_busy_start", 32'(busy), 32'd1);
      req = '0;
      tick(11);
      chk("t1_busy_idle", 32'(busy), 32'd0);

      // Restore the pointer, then four simultaneous requests: 255*255 = 65025
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(1);
      k = cyc;
      for (int j = 0; j < NREQ; j++) begin
         set_op(j, 8'd255, 8'd255);
         expect_op(j, 8'd255, 8'd255, 17'h0FE01, 1'b0, k + 1 + 12*j, k + 11 + 12*j, 1'b1);
      end
      req = 4'b1111;
      tick(37);
      req = '0;
      tick(11);

      // req0 pulses while req1 owns the multiplier: 12*10 = 120
      k = cyc;
      set_op(1, 8'd12, 8'd10);
      req = 4'b0010;
      expect_op(1, 8'd12, 8'd10, 17'd120, 1'b0, k + 1, k + 11, 1'b1);
      tick(1);
      req = '0;
      tick(2);
      set_op(0, 8'd1, 8'd1);
      req = 4'b0001;
      tick(1);
      req = '0;
      tick(10);

      // fin forced high in the START cycle: 17*9 = 153
      k = cyc;
      set_op(0, 8'd17, 8'd9);
      req = 4'b0001;
      expect_op(0, 8'd17, 8'd9, 17'd153, 1'b0, k + 1, k + 11, 1'b1);
      tick(1);
      force_fin = 1'b1;
      req = '0;
      tick(1);
      force_fin = 1'b0;
      tick(11);

      // Reset in the 4th WAIT cycle, then a fresh 3*5 = 15
      k = cyc;
      set_op(0, 8'd50, 8'd2);
      req = 4'b0001;
      expect_op(0, 8'd50, 8'd2, 17'd0, 1'b0, k + 1, 0, 1'b0);
      tick(1);
      req = '0;
      tick(4);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("t5_busy_after_rst",   32'(busy),   32'd0);
      chk("t5_result_after_rst", 32'(result), 32'd0);
      chk("t5_done_after_rst",   32'(done),   32'd0);
      tick(2);
      k = cyc;
      set_op(0, 8'd3, 8'd5);
      req = 4'b0001;
      expect_op(0, 8'd3, 8'd5, 17'd15, 1'b0, k + 1, k + 11, 1'b1);
      tick(1);
      req = '0;
      tick(12);
      chk("t5_result_hold", 32'(result), 32'd15);

`ifdef MUL_ARB_TIMEOUT_EN
      // Multiplier never finishes: timeout after 16 WAIT cycles, then 7*6 = 42
      k = cyc;
      stuck_fin = 1'b1;
      set_op(2, 8'd9, 8'd9);
      req = 4'b0100;
      expect_op(2, 8'd9, 8'd9, 17'd0, 1'b1, k + 1, k + 18, 1'b1);
      tick(1);
      req = '0;
      tick(17);
      stuck_fin = 1'b0;
      tick(1);
      k = cyc;
      set_op(3, 8'd7, 8'd6);
      req = 4'b1000;
      expect_op(3, 8'd7, 8'd6, 17'd42, 1'b0, k + 1, k + 11, 1'b1);
      tick(1);
      req = '0;
      tick(12);
`endif

      tick(2);
      chk("sb_gnt_drained",  32'(gnt_q.size()),  32'd0);
      chk("sb_done_drained", 32'(done_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d required=finish before time limit", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
